// File: rtl/uart_tx_arbiter.sv
// Round-robin arbiter sharing one UART transmitter among NREQ byte sources.
// Define UART_ARB_TIMEOUT_EN to add a watchdog on the wait-for-tx_done state.
module uart_tx_arbiter #(
  parameter int NREQ           = 4,
  parameter int DATABITS       = 8,
  parameter int GAP_CYCLES     = 16,
  parameter int TIMEOUT_CYCLES = 65536
) (
  input  logic                     clk,
  input  logic                     reset,
  input  logic [NREQ-1:0]          req_valid,
  input  logic [NREQ*DATABITS-1:0] req_data,
  output logic [NREQ-1:0]          req_ready,
  output logic                     tx_start,
  output logic [DATABITS-1:0]      tx_data,
  input  logic                     tx_done,
  output logic [$clog2(NREQ)-1:0]  grant_id,
  output logic                     busy,
  output logic                     timeout
);

  localparam int IW = $clog2(NREQ);
  localparam int GW = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;

  typedef enum logic [1:0] {
    IDLE,
    START,
    WAIT,
    GAP
  } state_e;

  state_e              state_q, state_d;
  logic [IW-1:0]       ptr_q, ptr_d;
  logic [IW-1:0]       grant_q, grant_d;
  logic [DATABITS-1:0] data_q, data_d;
  logic [GW-1:0]       gap_q, gap_d;

  logic [DATABITS-1:0] req_byte [NREQ];
  logic                found;
  logic [IW-1:0]       win;
  logic [IW-1:0]       cand;
  logic                wait_exit;

  always_comb begin
    for (int i = 0; i < NREQ; i++) begin
      req_byte[i] = req_data[i*DATABITS +: DATABITS];
    end
  end

  // First valid requester at or after the rotation pointer.
  always_comb begin
    found = 1'b0;
    win   = '0;
    cand  = '0;
    for (int k = 0; k < NREQ; k++) begin
      cand = IW'((int'(ptr_q) + k) % NREQ);
      if (!found && req_valid[cand]) begin
        found = 1'b1;
        win   = cand;
      end
    end
  end

  always_comb begin
    req_ready = '0;
    if (state_q == IDLE && !reset && found) begin
      req_ready[win] = 1'b1;
    end
  end

`ifdef UART_ARB_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES) + 1;
  logic [TW-1:0] wd_q, wd_d;

  always_comb begin
    wd_d = '0;
    if (state_q == WAIT) begin
      wd_d = wd_q + TW'(1);
    end
  end

  assign timeout = (state_q == WAIT) && !reset && !tx_done &&
                   (wd_q == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q <= '0;
    end else begin
      wd_q <= wd_d;
    end
  end
`else
  assign timeout = 1'b0;
`endif

  assign wait_exit = tx_done || timeout;

  always_comb begin
    state_d = state_q;
    ptr_d   = ptr_q;
    grant_d = grant_q;
    data_d  = data_q;
    gap_d   = gap_q;
    unique case (state_q)
      IDLE: begin
        if (found) begin
          data_d  = req_byte[win];
          grant_d = win;
          ptr_d   = IW'((int'(win) + 1) % NREQ);
          state_d = START;
        end
      end
      START: state_d = WAIT;
      WAIT: begin
        if (wait_exit) begin
          if (GAP_CYCLES == 0) begin
            state_d = IDLE;
          end else begin
            state_d = GAP;
            gap_d   = GW'(GAP_CYCLES - 1);
          end
        end
      end
      GAP: begin
        if (gap_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_d = gap_q - GW'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
      ptr_q   <= '0;
      grant_q <= '0;
      data_q  <= '0;
      gap_q   <= '0;
    end else begin
      state_q <= state_d;
      ptr_q   <= ptr_d;
      grant_q <= grant_d;
      data_q  <= data_d;
      gap_q   <= gap_d;
    end
  end

  assign tx_start = (state_q == START);
  assign busy     = (state_q != IDLE);
  assign tx_data  = data_q;
  assign grant_id = grant_q;

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter: directed scenarios plus random traffic,
// checked against a per-cycle frame/rotation model of the arbiter.
`timescale 1ns/1ps
module tb_uart_tx_arbiter;

  localparam int NREQ  = 4;
  localparam int DB    = 8;
  localparam int GAP   = 4;
  localparam int TXLAT = 20;
  localparam int TOC   = 50;
  localparam int FRAME = 2 + TXLAT + GAP;
`ifdef UART_ARB_TIMEOUT_EN
  localparam bit TO_EN = 1'b1;
`else
  localparam bit TO_EN = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            reset = 1'b1;
  logic [NREQ-1:0] req_valid = '0;
  logic [NREQ*DB-1:0] req_data = '0;
  logic [NREQ-1:0] req_ready;
  logic            tx_start;
  logic [DB-1:0]   tx_data;
  logic            tx_done = 1'b0;
  logic [1:0]      grant_id;
  logic            busy;
  logic            timeout;

  always #5 clk = ~clk;

  uart_tx_arbiter #(
    .NREQ(NREQ), .DATABITS(DB), .GAP_CYCLES(GAP), .TIMEOUT_CYCLES(TOC)
  ) dut (
    .clk(clk), .reset(reset), .req_valid(req_valid), .req_data(req_data),
    .req_ready(req_ready), .tx_start(tx_start), .tx_data(tx_data),
    .tx_done(tx_done), .grant_id(grant_id), .busy(busy), .timeout(timeout)
  );

  int checks = 0;
  int errors = 0;

  logic [7:0] q [NREQ][$];
  logic [7:0] log_q [$];
  logic [7:0] exp3 [5] = '{8'h10, 8'h11, 8'h12, 8'h13, 8'h10};

  int         cyc = 0;
  int         mptr = 0;
  int         next_free = 0;
  int         last_acc = -100;
  int         to_cyc = -1;
  int         nid = 0;
  logic [7:0] ndata = '0;
  logic [7:0] exp_data = '0;
  logic [1:0] exp_id = '0;
  bit         rst_prev = 1'b1;
  bit         rst_cmd = 1'b1;
  bit         grant_prev = 1'b0;
  bit         start_exp = 1'b0;
  bit         suppress = 1'b0;
  int         pend = 0;

  // UART transmitter: tx_done pulse TXLAT clocks after tx_start.
  initial forever begin
    @(negedge clk);
    tx_done = 1'b0;
    if (pend > 0) begin
      pend--;
      if (pend == 0) tx_done = 1'b1;
    end
    if (tx_start && !suppress) pend = TXLAT;
  end

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h cycle=%0d",
             tag, obs, exp, cyc);
    end
  endtask

  task automatic step();
    int w;
    logic [3:0] exp_rr;
    bit busy_exp;
    @(negedge clk);
    cyc++;
    if (rst_prev) begin
      exp_id = '0; exp_data = '0; start_exp = 1'b0; mptr = 0;
      next_free = cyc; last_acc = -100; to_cyc = -1;
    end else begin
      start_exp = grant_prev;
      if (grant_prev) begin
        exp_id = 2'(nid);
        exp_data = ndata;
        void'(q[nid].pop_front());
      end
    end
    grant_prev = 1'b0;
    reset = rst_cmd;
    for (int i = 0; i < NREQ; i++) begin
      req_valid[i] = (q[i].size() != 0);
      req_data[i*DB +: DB] = (q[i].size() != 0) ? q[i][0] : 8'($urandom);
    end
    #1;
    w = -1;
    if (!rst_cmd && cyc >= next_free) begin
      for (int k = 0; k < NREQ; k++) begin
        int idx;
        idx = (mptr + k) % NREQ;
        if (w < 0 && q[idx].size() != 0) w = idx;
      end
    end
    exp_rr = '0;
    if (w >= 0) exp_rr[w] = 1'b1;
    busy_exp = !rst_prev && cyc > last_acc && cyc < next_free;
    chk("req_ready", 32'(req_ready), 32'(exp_rr));
    chk("tx_start", 32'(tx_start), 32'(start_exp));
    chk("busy", 32'(busy), 32'(busy_exp));
    chk("tx_data", 32'(tx_data), 32'(exp_data));
    chk("grant_id", 32'(grant_id), 32'(exp_id));
    chk("timeout", 32'(timeout), 32'(cyc == to_cyc));
    if (w >= 0) begin
      grant_prev = 1'b1;
      nid = w;
      ndata = q[w][0];
      log_q.push_back(ndata);
      mptr = (w + 1) % NREQ;
      last_acc = cyc;
      if (!suppress) begin
        next_free = cyc + FRAME;
      end else if (TO_EN) begin
        next_free = cyc + 2 + TOC + GAP;
        to_cyc = cyc + 1 + TOC;
      end else begin
        next_free = cyc + 1000000;
      end
    end
    rst_prev = rst_cmd;
  endtask

  task automatic run(input int n);
    repeat (n) step();
  endtask

  task automatic pulse_reset();
    rst_cmd = 1'b1;
    step();
    rst_cmd = 1'b0;
  endtask

  initial begin
    // Reset held with all four requesters valid, then fair rotation from 0.
    q[0].push_back(8'h10); q[1].push_back(8'h11);
    q[2].push_back(8'h12); q[3].push_back(8'h13);
    q[0].push_back(8'h10);
    rst_cmd = 1'b1;
    run(3);
    rst_cmd = 1'b0;
    log_q.delete();
    run(5 * FRAME + 5);
    chk("all_valid_count", 32'(log_q.size()), 32'd5);
    for (int i = 0; i < 5; i++)
      if (i < log_q.size()) chk("all_valid_order", 32'(log_q[i]), 32'(exp3[i]));

    // Single requester, continuously valid.
    pulse_reset();
    log_q.delete();
    q[1].push_back(8'hA5); q[1].push_back(8'h5A);
    run(2 * FRAME + 5);
    chk("single_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() > 0) chk("single_first", 32'(log_q[0]), 32'hA5);

    // After req2 is served, req3 outranks req0.
    log_q.delete();
    q[2].push_back(8'h22);
    run(3);
    q[0].push_back(8'h30); q[3].push_back(8'h33);
    run(3 * FRAME);
    chk("rot_count", 32'(log_q.size()), 32'd3);
    if (log_q.size() == 3) begin
      chk("rot_0", 32'(log_q[0]), 32'h22);
      chk("rot_1", 32'(log_q[1]), 32'h33);
      chk("rot_2", 32'(log_q[2]), 32'h30);
    end

    // Reset during WAIT; the late tx_done must be ignored; pointer back at 0.
    pulse_reset();
    log_q.delete();
    q[1].push_back(8'h55);
    run(6);
    chk("midframe_busy", 32'(busy), 32'd1);
    pulse_reset();
    run(30);
    chk("midframe_count", 32'(log_q.size()), 32'd1);
    log_q.delete();
    q[1].push_back(8'h61); q[3].push_back(8'h63);
    run(2 * FRAME + 5);
    chk("after_rst_count", 32'(log_q.size()), 32'd2);
    if (log_q.size() == 2) begin
      chk("after_rst_0", 32'(log_q[0]), 32'h61);
      chk("after_rst_1", 32'(log_q[1]), 32'h63);
    end

    // tx_done never arrives.
    log_q.delete();
    suppress = 1'b1;
    q[0].push_back(8'h70); q[1].push_back(8'h71);
    run(130);
    chk("no_done_count", 32'(log_q.size()), TO_EN ? 32'd2 : 32'd1);
    rst_cmd = 1'b1;
    run(2);
    suppress = 1'b0;
    rst_cmd = 1'b0;

    // Random traffic.
    repeat (2000) begin
      if ($urandom_range(0, 3) == 0) begin
        int i;
        i = $urandom_range(0, NREQ - 1);
        if (q[i].size() < 3) q[i].push_back(8'($urandom));
      end
      step();
    end
    run(FRAME * 12 + 5);
    chk("drained", 32'(q[0].size() + q[1].size() + q[2].size() + q[3].size()), 32'd0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
